// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM states, the
// MEM-stage control encoding and which requester owns the current access.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } arb_state_e;

    typedef enum logic {
        PORT_IF,
        PORT_ME
    } port_sel_e;

    localparam logic [1:0] MEMCTL_NONE  = 2'b00;
    localparam logic [1:0] MEMCTL_READ  = 2'b01;
    localparam logic [1:0] MEMCTL_WRITE = 2'b10;
    localparam logic [1:0] MEMCTL_RSVD  = 2'b11;

    // The reserved code is not a request: it neither starts an access nor stalls.
    function automatic logic is_me_req(input logic [1:0] ctrl);
        return (ctrl != MEMCTL_NONE) && (ctrl != MEMCTL_RSVD);
    endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// 3-bit loadable down-counter that times SRAM strobe widths; zero_o flags
// that the current strobe phase has run its full length.
module mem_arb_wait_cnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [2:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 3'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one asynchronous SRAM between the fetch port and the MEM-stage data
// port; data wins arbitration. Define MEM_ARB_FETCH_BUF_EN for a one-entry fetch buffer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic [1:0]        me_ctrl,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [DATA_W-1:0] me_wdata,
    output logic [DATA_W-1:0] me_rdata,
    output logic              me_ready,
    output logic              stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    arb_state_e        state_q;
    port_sel_e         sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dq_o_q;
    logic              dq_oe_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] me_rdata_q;
    logic              if_ready_q;
    logic              me_ready_q;

    logic              me_req;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              fb_hit;
    logic [DATA_W-1:0] fb_data;

    assign me_req = is_me_req(me_ctrl);

    // Reload in IDLE for the read strobe and in WR_SETUP for the write pulse.
    assign cnt_load = (state_q == ST_IDLE) || (state_q == ST_WR_SETUP);
    assign cnt_dec  = ((state_q == ST_RD) || (state_q == ST_WR_PULSE)) && !cnt_zero;

    mem_arb_wait_cnt u_wait_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

`ifdef MEM_ARB_FETCH_BUF_EN
    logic              fb_valid_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [DATA_W-1:0] fb_data_q;

    assign fb_hit  = fb_valid_q && (fb_addr_q == if_addr);
    assign fb_data = fb_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_valid_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else if ((state_q == ST_RD) && cnt_zero && (sel_q == PORT_IF)) begin
            fb_valid_q <= 1'b1;
            fb_addr_q  <= addr_q;
            fb_data_q  <= sram_dq_i;
        end else if ((state_q == ST_IDLE) && (me_ctrl == MEMCTL_WRITE) && (me_addr == fb_addr_q)) begin
            fb_valid_q <= 1'b0;
        end
    end
`else
    assign fb_hit  = 1'b0;
    assign fb_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= PORT_IF;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            if_rdata_q <= '0;
            me_rdata_q <= '0;
            if_ready_q <= 1'b0;
            me_ready_q <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            me_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (me_req) begin
                        sel_q  <= PORT_ME;
                        addr_q <= me_addr;
                        ce_n_q <= 1'b0;
                        if (me_ctrl == MEMCTL_WRITE) begin
                            state_q <= ST_WR_SETUP;
                            dq_o_q  <= me_wdata;
                            dq_oe_q <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            oe_n_q  <= 1'b0;
                        end
                    end else if (if_req && fb_hit) begin
                        state_q    <= ST_DONE;
                        if_rdata_q <= fb_data;
                        if_ready_q <= 1'b1;
                    end else if (if_req) begin
                        state_q <= ST_RD;
                        sel_q   <= PORT_IF;
                        addr_q  <= if_addr;
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (cnt_zero) begin
                        state_q <= ST_DONE;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        if (sel_q == PORT_IF) begin
                            if_rdata_q <= sram_dq_i;
                            if_ready_q <= 1'b1;
                        end else begin
                            me_rdata_q <= sram_dq_i;
                            me_ready_q <= 1'b1;
                        end
                    end
                end
                ST_WR_SETUP: begin
                    state_q <= ST_WR_PULSE;
                    we_n_q  <= 1'b0;
                end
                ST_WR_PULSE: begin
                    if (cnt_zero) begin
                        state_q <= ST_WR_HOLD;
                        we_n_q  <= 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    state_q    <= ST_DONE;
                    ce_n_q     <= 1'b1;
                    dq_oe_q    <= 1'b0;
                    me_ready_q <= 1'b1;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall      = (if_req && !if_ready_q) || (me_req && !me_ready_q);
    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign me_rdata   = me_rdata_q;
    assign me_ready   = me_ready_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural SRAM, transaction-level timing model
// with a shadow memory, directed scenarios followed by randomized traffic.
module tb_mem_port_arbiter;

    localparam int W = 1;
`ifdef MEM_ARB_FETCH_BUF_EN
    localparam bit BUF_EN  = 1'b1;
    localparam int HIT_LAT = 1;
    localparam int HIT_CE  = 0;
`else
    localparam bit BUF_EN  = 1'b0;
    localparam int HIT_LAT = 3;
    localparam int HIT_CE  = 2;
`endif
    localparam logic [1:0] MC_NONE = 2'b00;
    localparam logic [1:0] MC_RD   = 2'b01;
    localparam logic [1:0] MC_WR   = 2'b10;
    localparam logic [1:0] MC_RSVD = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic [1:0]  me_ctrl;
    logic [15:0] me_addr;
    logic [15:0] me_wdata;
    logic [15:0] me_rdata;
    logic        me_ready;
    logic        stall;
    logic [15:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .me_ctrl(me_ctrl), .me_addr(me_addr), .me_wdata(me_wdata),
        .me_rdata(me_rdata), .me_ready(me_ready), .stall(stall),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    function automatic logic [15:0] init_val(input int i);
        if (i == 16'h0010) return 16'hABCD;
        return 16'(i) ^ 16'hA5A5;
    endfunction

    // Asynchronous SRAM: reads while ce&oe low, writes while ce&we low.
    logic [15:0] sram_mem [65536];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hDEAD;
    initial begin
        for (int i = 0; i < 65536; i++) sram_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_o;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: serialized accesses with edge-indexed timing.
    logic [15:0] ref_mem [65536];
    int          ecount = 0;
    int          free_edge = 0;
    int          if_rdy_edge = -1;
    int          me_rdy_edge = -1;
    int          acc_edge = 0;
    int          ce_hi_edge = 0;
    logic        cur_wr = 1'b0;
    logic [15:0] cur_addr = '0;
    logic [15:0] cur_wdata = '0;
    logic [15:0] if_pend_addr = '0, if_pend_data = '0, me_pend_data = '0;
    logic        me_pend_wr = 1'b0;
    logic [15:0] exp_if_rdata = '0, exp_me_rdata = '0;
    logic        exp_if_ready = 1'b0, exp_me_ready = 1'b0;
    logic        fb_valid = 1'b0;
    logic [15:0] fb_addr = '0;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b want %b (edge %0d)", name, act, exp, ecount);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, ecount);
        end
    endtask

    task automatic model_step();
        int  e;
        logic hit;
        ecount++;
        e = ecount;
        exp_if_ready = 1'b0;
        exp_me_ready = 1'b0;
        if (rst) begin
            free_edge = e + 1;  if_rdy_edge = -1;  me_rdy_edge = -1;
            acc_edge = e;  ce_hi_edge = e;  cur_wr = 1'b0;
            exp_if_rdata = '0;  exp_me_rdata = '0;  fb_valid = 1'b0;
        end else begin
            if (e >= free_edge) begin
                if (me_ctrl == MC_RD || me_ctrl == MC_WR) begin
                    acc_edge = e;  cur_addr = me_addr;  cur_wdata = me_wdata;
                    cur_wr = (me_ctrl == MC_WR);  me_pend_wr = cur_wr;
                    if (cur_wr) begin
                        ref_mem[me_addr] = me_wdata;
                        if (fb_addr == me_addr) fb_valid = 1'b0;
                        me_rdy_edge = e + 3 + W;  ce_hi_edge = e + 3 + W;  free_edge = e + 5 + W;
                    end else begin
                        me_pend_data = ref_mem[me_addr];
                        me_rdy_edge = e + 1 + W;  ce_hi_edge = e + 1 + W;  free_edge = e + 3 + W;
                    end
                end else if (if_req) begin
                    hit = BUF_EN && fb_valid && (fb_addr == if_addr);
                    acc_edge = e;  cur_addr = if_addr;  cur_wr = 1'b0;
                    if_pend_addr = if_addr;  if_pend_data = ref_mem[if_addr];
                    if (hit) begin
                        if_rdy_edge = e;  ce_hi_edge = e;  free_edge = e + 2;
                    end else begin
                        if_rdy_edge = e + 1 + W;  ce_hi_edge = e + 1 + W;  free_edge = e + 3 + W;
                    end
                end
            end
            if (e == if_rdy_edge) begin
                exp_if_ready = 1'b1;  exp_if_rdata = if_pend_data;
                fb_valid = 1'b1;  fb_addr = if_pend_addr;
            end
            if (e == me_rdy_edge) begin
                exp_me_ready = 1'b1;
                if (!me_pend_wr) exp_me_rdata = me_pend_data;
            end
        end
    endtask

    task automatic tick();
        logic active, exp_stall, me_is_req;
        @(posedge clk);
        model_step();
        #1;
        active    = (ecount >= acc_edge) && (ecount < ce_hi_edge);
        me_is_req = (me_ctrl == MC_RD) || (me_ctrl == MC_WR);
        exp_stall = (if_req && !exp_if_ready) || (me_is_req && !exp_me_ready);
        chk1("if_ready", if_ready, exp_if_ready);
        chk1("me_ready", me_ready, exp_me_ready);
        chk1("stall", stall, exp_stall);
        chk16("if_rdata", if_rdata, exp_if_rdata);
        chk16("me_rdata", me_rdata, exp_me_rdata);
        chk1("ce_n", sram_ce_n, !active);
        chk1("oe_n", sram_oe_n, !(active && !cur_wr));
        chk1("we_n", sram_we_n, !(cur_wr && ecount >= acc_edge + 1 && ecount < acc_edge + 2 + W));
        chk1("dq_oe", sram_dq_oe, active && cur_wr);
        chk1("oe_we_exclusive", !sram_oe_n && !sram_we_n, 1'b0);
        if (active) chk16("sram_addr", sram_addr, cur_addr);
        if (active && cur_wr) chk16("sram_dq_o", sram_dq_o, cur_wdata);
    endtask

    task automatic wait_rdy(input bit want_if, input int max, output int n, output int ce_lo);
        n = 0;
        ce_lo = 0;
        do begin
            tick();
            n++;
            if (!sram_ce_n) ce_lo++;
        end while (!(want_if ? if_ready : me_ready) && n < max);
    endtask

    initial begin
        int n, ce_lo, t_me, t_if, we_lo;
        logic st8, st10;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        rst = 1'b1;  if_req = 1'b1;  if_addr = 16'h0033;
        me_ctrl = MC_RD;  me_addr = 16'h0044;  me_wdata = '0;

        // Reset with both requests raised
        repeat (3) tick();
        chk1("t1_ce_n", sram_ce_n, 1'b1);
        chk1("t1_we_n", sram_we_n, 1'b1);
        chk1("t1_dq_oe", sram_dq_oe, 1'b0);
        chk16("t1_addr", sram_addr, 16'h0000);
        chk1("t1_stall", stall, 1'b1);
        if_req = 1'b0;  me_ctrl = MC_NONE;
        tick();
        rst = 1'b0;
        tick();

        // Plain fetch
        if_req = 1'b1;  if_addr = 16'h0010;
        wait_rdy(1'b1, 20, n, ce_lo);
        chkn("t2_latency", n, 3);
        chk16("t2_data", if_rdata, 16'hABCD);
        if_req = 1'b0;
        tick();

        // Simultaneous fetch and write
        if_req = 1'b1;  if_addr = 16'h0020;
        me_ctrl = MC_WR;  me_addr = 16'h0040;  me_wdata = 16'h1234;
        t_me = 0;  t_if = 0;  we_lo = 0;  st8 = 1'b0;  st10 = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (!sram_we_n) we_lo++;
            if (t == 8) st8 = stall;
            if (t == 10) st10 = stall;
            if (me_ready && t_me == 0) begin t_me = t; me_ctrl = MC_NONE; end
            if (if_ready && t_if == 0) begin t_if = t; if_req = 1'b0; end
        end
        chkn("t3_me_ready_cycle", t_me, 5);
        chkn("t3_if_ready_cycle", t_if, 9);
        chkn("t3_we_low_cycles", we_lo, 2);
        chk1("t3_stall_busy", st8, 1'b1);
        chk1("t3_stall_after", st10, 1'b0);

        // Write then read the same word
        me_ctrl = MC_WR;  me_addr = 16'h0005;  me_wdata = 16'h5A5A;
        wait_rdy(1'b0, 20, n, ce_lo);
        me_ctrl = MC_NONE;
        tick();
        me_ctrl = MC_RD;
        wait_rdy(1'b0, 20, n, ce_lo);
        chk16("t4_readback", me_rdata, 16'h5A5A);
        me_ctrl = MC_NONE;
        tick();

        // Reset during the write pulse
        me_ctrl = MC_WR;  me_addr = 16'h0050;  me_wdata = 16'hC3C3;
        tick();
        tick();
        chk1("t5_in_pulse", sram_we_n, 1'b0);
        rst = 1'b1;
        tick();
        chk1("t5_we_n", sram_we_n, 1'b1);
        chk1("t5_ce_n", sram_ce_n, 1'b1);
        chk1("t5_dq_oe", sram_dq_oe, 1'b0);
        chk1("t5_no_ready", me_ready, 1'b0);
        me_ctrl = MC_NONE;  rst = 1'b0;
        tick();
        chk1("t5_word_old_or_new",
             (sram_mem[16'h0050] == init_val(16'h0050)) || (sram_mem[16'h0050] == 16'hC3C3), 1'b1);
        ref_mem[16'h0050] = sram_mem[16'h0050];

        // Refetch, then refetch after a write to the same word
        if_req = 1'b1;  if_addr = 16'h0010;
        wait_rdy(1'b1, 20, n, ce_lo);
        if_req = 1'b0;
        tick();
        if_req = 1'b1;
        wait_rdy(1'b1, 20, n, ce_lo);
        chkn("t6_hit_latency", n, HIT_LAT);
        chkn("t6_hit_ce_cycles", ce_lo, HIT_CE);
        chk16("t6_hit_data", if_rdata, 16'hABCD);
        if_req = 1'b0;
        tick();
        me_ctrl = MC_WR;  me_addr = 16'h0010;  me_wdata = 16'h7777;
        wait_rdy(1'b0, 20, n, ce_lo);
        me_ctrl = MC_NONE;
        tick();
        if_req = 1'b1;
        wait_rdy(1'b1, 20, n, ce_lo);
        chkn("t6_miss_latency", n, 3);
        chk16("t6_new_data", if_rdata, 16'h7777);
        if_req = 1'b0;
        tick();

        // Randomized traffic on a small address window
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (exp_if_ready) if_req = 1'b0;
            if (exp_me_ready || me_ctrl == MC_RSVD) me_ctrl = MC_NONE;
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req  = 1'b1;
                if_addr = 16'($urandom_range(0, 31));
            end
            if (me_ctrl == MC_NONE && $urandom_range(0, 4) == 0) begin
                n = int'($urandom_range(0, 9));
                me_ctrl  = (n < 4) ? MC_RD : (n < 8) ? MC_WR : MC_RSVD;
                me_addr  = 16'($urandom_range(0, 31));
                me_wdata = 16'($urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
